// File: rtl/adpcm_encoder.sv
// rtl/adpcm_encoder.sv - IMA ADPCM encoder, one magnitude bit per cycle
// Tracks the decoder-side predictor and step index so both stay in lockstep.
module adpcm_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_sample,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_code,
   output logic [15:0] pred_out,
   output logic [6:0]  index_out
);

   typedef enum logic [2:0] {IDLE, SUB, B2, B1, B0, UPD, OUT} state_t;

   localparam logic [15:0] STEP [0:88] = '{
      16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,
      16'd16,    16'd17,    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,
      16'd34,    16'd37,    16'd41,    16'd45,    16'd50,    16'd55,    16'd60,    16'd66,
      16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,   16'd130,   16'd143,
      16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
      16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,
      16'd724,   16'd796,   16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,
      16'd1552,  16'd1707,  16'd1878,  16'd2066,  16'd2272,  16'd2499,  16'd2749,  16'd3024,
      16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,  16'd5894,  16'd6484,
      16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
      16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794,
      16'd32767
   };

   state_t             state, state_nx;
   logic signed [15:0] sample_r;
   logic signed [15:0] predictor;
   logic [6:0]         index;
   logic [16:0]        mag;
   logic [15:0]        step_r;
   logic [15:0]        diffq;
   logic               sign;
   logic [2:0]         bits;

   logic signed [16:0] diff;
   logic [16:0]        mag_abs;
   logic [15:0]        cur_s;
   logic               ge;
   logic signed [17:0] p_sum;
   logic signed [7:0]  adj;
   logic signed [7:0]  idx_sum;
   logic [6:0]         idx_clamped;

   assign in_ready  = (state == IDLE) && !rst;
   assign pred_out  = predictor;
   assign index_out = index;

   always_comb begin
      diff    = $signed({sample_r[15], sample_r}) - $signed({predictor[15], predictor});
      mag_abs = diff[16] ? 17'(-diff) : 17'(diff);
   end

   // Trial subtrahend shrinks by one bit per quantize state.
   always_comb begin
      cur_s = step_r;
      case (state)
         B1:      cur_s = step_r >> 1;
         B0:      cur_s = step_r >> 2;
         default: cur_s = step_r;
      endcase
      ge = (mag >= {1'b0, cur_s});
   end

   always_comb begin
      if (sign)
         p_sum = $signed({{2{predictor[15]}}, predictor}) - $signed({2'b00, diffq});
      else
         p_sum = $signed({{2{predictor[15]}}, predictor}) + $signed({2'b00, diffq});
   end

   always_comb begin
      case (bits)
         3'd4:    adj = 8'sd2;
         3'd5:    adj = 8'sd4;
         3'd6:    adj = 8'sd6;
         3'd7:    adj = 8'sd8;
         default: adj = -8'sd1;
      endcase
      idx_sum = $signed({1'b0, index}) + adj;
      if (idx_sum < 0)
         idx_clamped = 7'd0;
      else if (idx_sum > 8'sd88)
         idx_clamped = 7'd88;
      else
         idx_clamped = idx_sum[6:0];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid && in_ready) state_nx = SUB;
         SUB:     state_nx = B2;
         B2:      state_nx = B1;
         B1:      state_nx = B0;
         B0:      state_nx = UPD;
         UPD:     state_nx = OUT;
         OUT:     if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_r  <= '0;
         predictor <= '0;
         index     <= '0;
         mag       <= '0;
         step_r    <= '0;
         diffq     <= '0;
         sign      <= 1'b0;
         bits      <= '0;
         out_code  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid)
                  sample_r <= in_sample;
            end
            SUB: begin
               sign   <= diff[16];
               mag    <= mag_abs;
               step_r <= STEP[index];
               diffq  <= STEP[index] >> 3;
               bits   <= '0;
            end
            B2, B1, B0: begin
               if (ge) begin
                  mag   <= mag - {1'b0, cur_s};
                  diffq <= diffq + cur_s;
                  case (state)
                     B2:      bits[2] <= 1'b1;
                     B1:      bits[1] <= 1'b1;
                     default: bits[0] <= 1'b1;
                  endcase
               end
            end
            UPD: begin
               if (p_sum > 18'sd32767)
                  predictor <= 16'sh7fff;
               else if (p_sum < -18'sd32768)
                  predictor <= 16'sh8000;
               else
                  predictor <= p_sum[15:0];
               index     <= idx_clamped;
               out_code  <= {sign, bits};
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready)
                  out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_adpcm_encoder.sv
// tb/tb_adpcm_encoder.sv - randomized bench for adpcm_encoder against an IMA reference
module tb_adpcm_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_sample;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_code;
   logic [15:0] pred_out;
   logic [6:0]  index_out;

   int total = 0;
   int bad   = 0;
   int m_pred = 0;
   int m_idx  = 0;
   int last_code = 0;

   int step_t [89] = '{
      7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
      50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
      253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
      1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
      3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487,
      12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
   };
   int adj_t [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

   always #5 clk = ~clk;

   adpcm_encoder dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .pred_out(pred_out), .index_out(index_out)
   );

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Textbook IMA encode step, also advancing the decoder-side state.
   task automatic model_step(input int s, output int code);
      int diff, step, dq;
      code = 0;
      step = step_t[m_idx];
      diff = s - m_pred;
      if (diff < 0) begin
         code = 8;
         diff = -diff;
      end
      dq = step / 8;
      if (diff >= step) begin code += 4; diff -= step; dq += step; end
      step = step / 2;
      if (diff >= step) begin code += 2; diff -= step; dq += step; end
      step = step / 2;
      if (diff >= step) begin code += 1; dq += step; end
      m_pred = (code >= 8) ? m_pred - dq : m_pred + dq;
      if (m_pred > 32767)  m_pred = 32767;
      if (m_pred < -32768) m_pred = -32768;
      m_idx = m_idx + adj_t[code % 8];
      if (m_idx < 0)  m_idx = 0;
      if (m_idx > 88) m_idx = 88;
   endtask

   task automatic send(input int s);
      int code, n;
      n = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      check("accept_ready", int'(in_ready), 1);
      in_valid  = 1'b1;
      in_sample = 16'(s);
      @(posedge clk); #1;
      in_valid = 1'b0;
      model_step(s, code);
      last_code = code;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      check("latency", n, 5);
      check("code", int'(out_code), code);
      check("pred", int'($signed(pred_out)), m_pred);
      check("index", int'(index_out), m_idx);
      if (out_ready) begin
         @(posedge clk); #1;
         check("valid_drop", int'(out_valid), 0);
         check("ready_back", int'(in_ready), 1);
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", int'(in_ready), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_pred", int'($signed(pred_out)), 0);
      check("rst_index", int'(index_out), 0);
      check("rst_code", int'(out_code), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", int'(in_ready), 1);

      send(0);
      check("zero_code", int'(out_code), 0);
      check("zero_pred", int'($signed(pred_out)), 0);
      check("zero_index", int'(index_out), 0);

      send(100);
      check("pos_code", int'(out_code), 7);
      check("pos_pred", int'($signed(pred_out)), 11);
      check("pos_index", int'(index_out), 8);
      send(100);
      check("pos2_code", int'(out_code), 7);
      check("pos2_pred", int'($signed(pred_out)), 41);
      check("pos2_index", int'(index_out), 16);

      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      m_pred = 0; m_idx = 0;
      send(-100);
      check("neg_code", int'(out_code), 15);
      check("neg_pred", int'($signed(pred_out)), -11);
      check("neg_index", int'(index_out), 8);

      for (int i = 0; i < 60; i++) begin
         send(32767);
         check("sat_hi_index", int'(index_out <= 7'd88), 1);
      end
      for (int i = 0; i < 60; i++) send(-32768);

      for (int i = 0; i < 40; i++) send(int'($signed(16'($urandom))));
      for (int i = 0; i < 40; i++) send(m_pred + int'($urandom_range(0, 600)) - 300);

      // Back-pressure: code must hold and input must stay blocked.
      out_ready = 1'b0;
      send(int'($signed(16'($urandom))));
      for (int i = 0; i < 10; i++) begin
         in_valid  = i[0];
         in_sample = 16'($urandom);
         @(posedge clk); #1;
         check("hold_code", int'(out_code), last_code);
         check("hold_valid", int'(out_valid), 1);
         check("hold_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valid", int'(out_valid), 0);
      check("release_ready", int'(in_ready), 1);
      send(int'($signed(16'($urandom))));

      // Reset while the quantizer is in B1.
      in_valid = 1'b1; in_sample = 16'sd5000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_pred", int'($signed(pred_out)), 0);
      check("midrst_index", int'(index_out), 0);
      check("midrst_ready", int'(in_ready), 0);
      rst = 1'b0;
      m_pred = 0; m_idx = 0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) cnt++;
      end
      check("midrst_no_code", cnt, 0);
      send(100);
      check("after_rst_pred", int'($signed(pred_out)), 11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
